ysyx_23060077_id_ctrl: RTL and testbench

YSYX_23060077_ID_CTRL -- requirements
Module: ysyx_23060077_id_ctrl

---
 rtl/ysyx_23060077_id_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_ysyx_23060077_id_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060077_id_ctrl.sv
// Decode-stage control: a 2-entry skid FIFO between fetch and execute, with
// immediate extraction for the head instruction and a blocked-cycle counter.

`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module ysyx_23060077_id_imm #(
    parameter int INST_WIDTH = `INST_WIDTH,
    parameter int DATA_WIDTH = `DATA_WIDTH
) (
    input  logic [INST_WIDTH-1:0] i_inst,
    output logic [DATA_WIDTH-1:0] o_imm
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic [31:0] w_inst;
    logic [31:0] w_imm32;

    assign w_inst = i_inst[31:0];

    // OP, FENCE and anything unrecognised carry no immediate.
    always_comb begin
        w_imm32 = '0;
        case (w_inst[6:0])
            OP_LUI, OP_AUIPC:
                w_imm32 = {w_inst[31:12], 12'b0};
            OP_JAL:
                w_imm32 = {{12{w_inst[31]}}, w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};
            OP_JALR, OP_LOAD, OP_IMM, OP_SYSTEM:
                w_imm32 = {{20{w_inst[31]}}, w_inst[31:20]};
            OP_BRANCH:
                w_imm32 = {{20{w_inst[31]}}, w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
            OP_STORE:
                w_imm32 = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
            default:
                w_imm32 = '0;
        endcase
    end

    generate
        if (DATA_WIDTH > 32) begin : g_sext
            assign o_imm = {{(DATA_WIDTH-32){w_imm32[31]}}, w_imm32};
        end else begin : g_trunc
            assign o_imm = w_imm32[DATA_WIDTH-1:0];
        end
    endgenerate
endmodule

module ysyx_23060077_id_ctrl #(
    parameter int INST_WIDTH = `INST_WIDTH,
    parameter int DATA_WIDTH = `DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  if_valid,
    input  logic [INST_WIDTH-1:0] if_inst,
    input  logic [DATA_WIDTH-1:0] if_pc,
    output logic                  if_ready,
    output logic                  id_valid,
    output logic [INST_WIDTH-1:0] id_inst,
    output logic [DATA_WIDTH-1:0] id_pc,
    output logic [DATA_WIDTH-1:0] id_imm,
    input  logic                  ex_ready,
    input  logic                  hazard_stall,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] stall_cnt
);
    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_TWO   = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic                  r_if_ready;
    logic [INST_WIDTH-1:0] r_head_inst;
    logic [INST_WIDTH-1:0] r_tail_inst;
    logic [DATA_WIDTH-1:0] r_head_pc;
    logic [DATA_WIDTH-1:0] r_tail_pc;
    logic [DATA_WIDTH-1:0] r_stall_cnt;

    logic w_valid;
    logic w_acc;
    logic w_iss;
    logic w_head_from_if;
    logic w_tail_from_if;
    logic w_head_from_tail;

    assign w_valid = (r_state != S_EMPTY);
    assign w_acc   = if_valid & r_if_ready & ~flush;
    assign w_iss   = w_valid & ex_ready & ~hazard_stall & ~flush;

    // Accept-and-issue in ONE replaces the head in place, which keeps
    // back-to-back traffic bubble-free without ever touching the tail.
    always_comb begin
        w_state_nxt      = r_state;
        w_head_from_if   = 1'b0;
        w_tail_from_if   = 1'b0;
        w_head_from_tail = 1'b0;
        if (flush) begin
            w_state_nxt = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_acc) begin
                        w_state_nxt    = S_ONE;
                        w_head_from_if = 1'b1;
                    end
                end
                S_ONE: begin
                    if (w_acc && w_iss) begin
                        w_head_from_if = 1'b1;
                    end else if (w_acc) begin
                        w_state_nxt    = S_TWO;
                        w_tail_from_if = 1'b1;
                    end else if (w_iss) begin
                        w_state_nxt = S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (w_iss) begin
                        w_state_nxt      = S_ONE;
                        w_head_from_tail = 1'b1;
                    end
                end
                default: w_state_nxt = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_EMPTY;
            r_if_ready <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_if_ready <= (w_state_nxt != S_TWO);
        end
    end

    // Payload registers only move when written; popped entries keep stale data.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_head_inst <= '0;
            r_head_pc   <= '0;
            r_tail_inst <= '0;
            r_tail_pc   <= '0;
        end else begin
            if (w_head_from_if) begin
                r_head_inst <= if_inst;
                r_head_pc   <= if_pc;
            end else if (w_head_from_tail) begin
                r_head_inst <= r_tail_inst;
                r_head_pc   <= r_tail_pc;
            end
            if (w_tail_from_if) begin
                r_tail_inst <= if_inst;
                r_tail_pc   <= if_pc;
            end
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_valid && !w_iss && !flush && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + DATA_WIDTH'(1);
        end
    end

    ysyx_23060077_id_imm #(
        .INST_WIDTH (INST_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_imm (
        .i_inst (r_head_inst),
        .o_imm  (id_imm)
    );

    assign if_ready  = r_if_ready;
    assign id_valid  = w_valid;
    assign id_inst   = r_head_inst;
    assign id_pc     = r_head_pc;
    assign stall_cnt = r_stall_cnt;
endmodule

// File: tb/tb_ysyx_23060077_id_ctrl.sv
// Bench for the decode FIFO: directed vector table, async-reset and counter
// saturation sequences, then random traffic against a queue-based model.

module tb_ysyx_23060077_id_ctrl;
    logic        clock = 1'b0;
    logic        rst_n = 1'b1;
    logic        if_valid = 1'b0;
    logic [31:0] if_inst = '0;
    logic [31:0] if_pc = '0;
    logic        if_ready;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [31:0] id_imm;
    logic        ex_ready = 1'b0;
    logic        hazard_stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] stall_cnt;

    // Narrow-counter instance so saturation is reachable in a few cycles.
    logic        s_if_valid = 1'b0;
    logic [31:0] s_if_inst = '0;
    logic [3:0]  s_if_pc = '0;
    logic        s_if_ready;
    logic        s_id_valid;
    logic [31:0] s_id_inst;
    logic [3:0]  s_id_pc;
    logic [3:0]  s_id_imm;
    logic        s_ex_ready = 1'b0;
    logic        s_hazard = 1'b0;
    logic        s_flush = 1'b0;
    logic [3:0]  s_cnt;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    ysyx_23060077_id_ctrl #(.INST_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clock(clock), .rst_n(rst_n), .if_valid(if_valid), .if_inst(if_inst),
        .if_pc(if_pc), .if_ready(if_ready), .id_valid(id_valid), .id_inst(id_inst),
        .id_pc(id_pc), .id_imm(id_imm), .ex_ready(ex_ready),
        .hazard_stall(hazard_stall), .flush(flush), .stall_cnt(stall_cnt)
    );

    ysyx_23060077_id_ctrl #(.INST_WIDTH(32), .DATA_WIDTH(4)) u_sat (
        .clock(clock), .rst_n(rst_n), .if_valid(s_if_valid), .if_inst(s_if_inst),
        .if_pc(s_if_pc), .if_ready(s_if_ready), .id_valid(s_id_valid), .id_inst(s_id_inst),
        .id_pc(s_id_pc), .id_imm(s_id_imm), .ex_ready(s_ex_ready),
        .hazard_stall(s_hazard), .flush(s_flush), .stall_cnt(s_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        v;
        logic [31:0] inst;
        logic [31:0] pc;
        logic        exr, hz, fl;
        logic        e_valid, e_ready;
        logic [31:0] e_inst, e_pc, e_imm, e_cnt;
    } vec_t;

    function automatic vec_t mk(logic v, logic [31:0] inst, logic [31:0] pc,
                                logic exr, logic hz, logic fl, logic ev, logic er,
                                logic [31:0] ei, logic [31:0] ep, logic [31:0] em,
                                logic [31:0] ec);
        vec_t t;
        t.v = v; t.inst = inst; t.pc = pc; t.exr = exr; t.hz = hz; t.fl = fl;
        t.e_valid = ev; t.e_ready = er; t.e_inst = ei; t.e_pc = ep;
        t.e_imm = em; t.e_cnt = ec;
        return t;
    endfunction

    // Reference immediate, assembled field by field with shifts and masks.
    function automatic logic [31:0] ref_imm(logic [31:0] i);
        logic [31:0] sgn;
        sgn = i[31] ? 32'hFFFF_FFFF : 32'h0;
        case (i[6:0])
            7'h37, 7'h17: return i & 32'hFFFF_F000;
            7'h6F: return (sgn << 20) | (i & 32'h000F_F000) | (((i >> 20) & 1) << 11)
                          | (((i >> 21) & 1023) << 1);
            7'h67, 7'h03, 7'h13, 7'h73: return (sgn << 12) | (i >> 20);
            7'h63: return (sgn << 12) | (((i >> 7) & 1) << 11) | (((i >> 25) & 63) << 5)
                          | (((i >> 8) & 15) << 1);
            7'h23: return (sgn << 12) | ((i >> 25) << 5) | ((i >> 7) & 31);
            default: return 32'h0;
        endcase
    endfunction

    typedef struct packed { logic [31:0] inst; logic [31:0] pc; } ent_t;
    ent_t        mq[$];
    logic        m_ready;
    logic [31:0] m_cnt, m_inst, m_pc;

    task automatic model_step(logic v, logic [31:0] inst, logic [31:0] pc,
                              logic exr, logic hz, logic fl);
        logic acc, iss;
        ent_t e;
        acc = v & m_ready & ~fl;
        iss = (mq.size() != 0) & exr & ~hz & ~fl;
        if (mq.size() != 0 && !iss && !fl && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        if (fl) mq.delete();
        else begin
            if (iss) void'(mq.pop_front());
            if (acc) begin e.inst = inst; e.pc = pc; mq.push_back(e); end
        end
        m_ready = (mq.size() != 2);
        if (mq.size() != 0) begin m_inst = mq[0].inst; m_pc = mq[0].pc; end
    endtask

    localparam logic [31:0] A  = 32'h0050_0093;
    localparam logic [31:0] B1 = 32'h0010_0113, B2 = 32'h0020_0193, B3 = 32'h0030_0213;
    localparam logic [31:0] C1 = 32'h0040_0293, C2 = 32'h0060_0313, C3 = 32'h0070_0393;

    vec_t tbl[28];
    logic [6:0] ops[12];

    initial begin
        tbl[0]  = mk(0, 0, 0, 0,0,0, 0,1, 0, 0, 0, 0);
        tbl[1]  = mk(1, A, 32'h8000_0000, 1,0,0, 1,1, A, 32'h8000_0000, 5, 0);
        tbl[2]  = mk(1, A, 32'h8000_0004, 1,0,0, 1,1, A, 32'h8000_0004, 5, 0);
        tbl[3]  = mk(1, A, 32'h8000_0008, 1,0,0, 1,1, A, 32'h8000_0008, 5, 0);
        tbl[4]  = mk(1, A, 32'h8000_000C, 1,0,0, 1,1, A, 32'h8000_000C, 5, 0);
        tbl[5]  = mk(0, 0, 0, 1,0,0, 0,1, A, 32'h8000_000C, 5, 0);
        tbl[6]  = mk(1, B1, 32'h100, 0,0,0, 1,1, B1, 32'h100, 1, 0);
        tbl[7]  = mk(1, B2, 32'h104, 0,0,0, 1,0, B1, 32'h100, 1, 1);
        tbl[8]  = mk(1, B3, 32'h108, 0,0,0, 1,0, B1, 32'h100, 1, 2);
        tbl[9]  = mk(1, B3, 32'h108, 1,0,0, 1,1, B2, 32'h104, 2, 2);
        tbl[10] = mk(1, B3, 32'h108, 1,0,0, 1,1, B3, 32'h108, 3, 2);
        tbl[11] = mk(0, 0, 0, 1,0,0, 0,1, B3, 32'h108, 3, 2);
        tbl[12] = mk(1, C1, 32'h200, 0,0,0, 1,1, C1, 32'h200, 4, 2);
        tbl[13] = mk(1, C2, 32'h204, 0,0,0, 1,0, C1, 32'h200, 4, 3);
        tbl[14] = mk(1, C3, 32'h208, 1,0,1, 0,1, C1, 32'h200, 4, 3);
        tbl[15] = mk(0, 0, 0, 1,0,0, 0,1, C1, 32'h200, 4, 3);
        tbl[16] = mk(1, 32'hFE00_0EE3, 32'h300, 1,0,0, 1,1, 32'hFE00_0EE3, 32'h300, 32'hFFFF_FFFC, 3);
        tbl[17] = mk(1, 32'h8000_00EF, 32'h304, 1,0,0, 1,1, 32'h8000_00EF, 32'h304, 32'hFFF0_0000, 3);
        tbl[18] = mk(1, 32'h1234_5037, 32'h308, 1,0,0, 1,1, 32'h1234_5037, 32'h308, 32'h1234_5000, 3);
        tbl[19] = mk(0, 0, 0, 1,1,0, 1,1, 32'h1234_5037, 32'h308, 32'h1234_5000, 4);
        tbl[20] = mk(0, 0, 0, 1,1,0, 1,1, 32'h1234_5037, 32'h308, 32'h1234_5000, 5);
        tbl[21] = mk(0, 0, 0, 1,1,0, 1,1, 32'h1234_5037, 32'h308, 32'h1234_5000, 6);
        tbl[22] = mk(0, 0, 0, 1,0,0, 0,1, 32'h1234_5037, 32'h308, 32'h1234_5000, 6);
        tbl[23] = mk(1, 32'h0020_81B3, 32'h400, 0,0,0, 1,1, 32'h0020_81B3, 32'h400, 0, 6);
        tbl[24] = mk(0, 0, 0, 1,0,0, 0,1, 32'h0020_81B3, 32'h400, 0, 6);
        tbl[25] = mk(1, 32'h0FF0_000F, 32'h404, 1,0,0, 1,1, 32'h0FF0_000F, 32'h404, 0, 6);
        tbl[26] = mk(1, 32'hFE11_2C23, 32'h408, 1,0,0, 1,1, 32'hFE11_2C23, 32'h408, 32'hFFFF_FFF8, 6);
        tbl[27] = mk(0, 0, 0, 1,0,0, 0,1, 32'hFE11_2C23, 32'h408, 32'hFFFF_FFF8, 6);
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h73, 7'h63, 7'h23, 7'h33, 7'h0F, 7'h7F};

        // Asynchronous reset assertion, away from any clock edge.
        #2 rst_n = 1'b0;
        #1;
        chk("reset id_valid", 32'(id_valid), 32'd0);
        chk("reset if_ready", 32'(if_ready), 32'd0);
        chk("reset stall_cnt", stall_cnt, 32'd0);
        chk("reset id_inst", id_inst, 32'd0);
        chk("reset id_pc", id_pc, 32'd0);
        chk("reset id_imm", id_imm, 32'd0);
        @(negedge clock);
        rst_n = 1'b1;

        for (int r = 0; r < 28; r++) begin
            if_valid = tbl[r].v; if_inst = tbl[r].inst; if_pc = tbl[r].pc;
            ex_ready = tbl[r].exr; hazard_stall = tbl[r].hz; flush = tbl[r].fl;
            @(negedge clock);
            chk($sformatf("row%0d id_valid", r), 32'(id_valid), 32'(tbl[r].e_valid));
            chk($sformatf("row%0d if_ready", r), 32'(if_ready), 32'(tbl[r].e_ready));
            chk($sformatf("row%0d id_inst", r), id_inst, tbl[r].e_inst);
            chk($sformatf("row%0d id_pc", r), id_pc, tbl[r].e_pc);
            chk($sformatf("row%0d id_imm", r), id_imm, tbl[r].e_imm);
            chk($sformatf("row%0d stall_cnt", r), stall_cnt, tbl[r].e_cnt);
        end

        // Fill both entries, then pull reset low mid-cycle.
        if_valid = 1'b1; if_inst = 32'h0080_0413; if_pc = 32'h500;
        ex_ready = 1'b0; hazard_stall = 1'b0; flush = 1'b0;
        @(negedge clock);
        if_inst = 32'h0090_0493; if_pc = 32'h504;
        @(negedge clock);
        chk("two id_valid", 32'(id_valid), 32'd1);
        chk("two if_ready", 32'(if_ready), 32'd0);
        if_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midreset id_valid", 32'(id_valid), 32'd0);
        chk("midreset if_ready", 32'(if_ready), 32'd0);
        chk("midreset stall_cnt", stall_cnt, 32'd0);
        chk("midreset id_inst", id_inst, 32'd0);
        chk("midreset id_pc", id_pc, 32'd0);
        chk("midreset id_imm", id_imm, 32'd0);
        @(negedge clock);
        rst_n = 1'b1;
        #1 chk("release if_ready before edge", 32'(if_ready), 32'd0);
        @(negedge clock);
        chk("release if_ready", 32'(if_ready), 32'd1);
        chk("release id_valid", 32'(id_valid), 32'd0);

        // Counter saturation on the narrow instance: 14 blocked cycles reach
        // all-ones-minus-one, 3 more must stick at all-ones.
        s_if_valid = 1'b1; s_if_inst = A; s_if_pc = 4'h3; s_ex_ready = 1'b0;
        @(negedge clock);
        s_if_valid = 1'b0;
        chk("sat start", 32'(s_cnt), 32'd0);
        chk("sat id_valid", 32'(s_id_valid), 32'd1);
        chk("sat id_inst", s_id_inst, A);
        chk("sat id_pc", 32'(s_id_pc), 32'h3);
        chk("sat id_imm", 32'(s_id_imm), 32'h5);
        for (int k = 0; k < 14; k++) @(negedge clock);
        chk("sat preset", 32'(s_cnt), 32'hE);
        for (int k = 0; k < 3; k++) @(negedge clock);
        chk("sat hold", 32'(s_cnt), 32'hF);
        s_ex_ready = 1'b1;
        @(negedge clock);
        chk("sat drain if_ready", 32'(s_if_ready), 32'd1);
        chk("sat drain id_valid", 32'(s_id_valid), 32'd0);

        // Random traffic against the queue model.
        mq.delete();
        m_ready = 1'b1; m_cnt = 0; m_inst = 0; m_pc = 0;
        for (int c = 0; c < 1500; c++) begin
            logic [31:0] rw;
            chk($sformatf("rnd%0d id_valid", c), 32'(id_valid), 32'(mq.size() != 0));
            chk($sformatf("rnd%0d if_ready", c), 32'(if_ready), 32'(m_ready));
            chk($sformatf("rnd%0d id_inst", c), id_inst, m_inst);
            chk($sformatf("rnd%0d id_pc", c), id_pc, m_pc);
            chk($sformatf("rnd%0d id_imm", c), id_imm, ref_imm(m_inst));
            chk($sformatf("rnd%0d stall_cnt", c), stall_cnt, m_cnt);
            rw = $urandom();
            if_valid = ($urandom_range(0, 9) < 7);
            if_inst = {rw[31:7], ops[$urandom_range(0, 11)]};
            if_pc = $urandom();
            ex_ready = ($urandom_range(0, 9) < 6);
            hazard_stall = ($urandom_range(0, 9) < 2);
            flush = ($urandom_range(0, 19) == 0);
            model_step(if_valid, if_inst, if_pc, ex_ready, hazard_stall, flush);
            @(negedge clock);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
